// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready stage with a one-entry skid buffer feeding a flopenr (out_en drives its enable).
// Optional back-pressure statistics counter enabled by the PIPE_SKID_STATS_EN macro.
module pipe_skid_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_en,
  output logic [15:0]      stall_cnt
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] m_nxt_s;
  logic [WIDTH-1:0] s_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             deliver_s;

  assign accept_s  = in_valid & in_ready_r;
  assign deliver_s = out_valid_r & out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = m_r;
  assign out_en    = deliver_s;

  // Next-state and data-load selection; flush empties the stage but leaves data registers untouched.
  always_comb begin
    state_nxt_s = state_r;
    m_nxt_s     = m_r;
    s_nxt_s     = s_r;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            m_nxt_s     = in_data;
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && deliver_s) begin
            m_nxt_s     = in_data;
            state_nxt_s = ONE;
          end else if (accept_s) begin
            s_nxt_s     = in_data;
            state_nxt_s = FULL;
          end else if (deliver_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        FULL: begin
          if (deliver_s) begin
            m_nxt_s     = s_r;
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // State, data and handshake flags; in_ready/out_valid are registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= EMPTY;
      m_r         <= {WIDTH{1'b0}};
      s_r         <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      m_r         <= m_nxt_s;
      s_r         <= s_nxt_s;
      in_ready_r  <= (state_nxt_s != FULL);
      out_valid_r <= (state_nxt_s != EMPTY);
    end
  end

`ifdef PIPE_SKID_STATS_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles where a held beat is refused downstream; flush clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 16'h0000;
    end else if (flush) begin
      stall_cnt_r <= 16'h0000;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
